// File: rtl/amci_rr_arbiter_if.sv
// Bundle of requester-side and AMCI-side signals around the round-robin arbiter.
// master: the arbiter's view. slave: the view of whatever surrounds it
// (requesters plus the AXI4-Lite master).
interface amci_rr_arbiter_if #(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_AXI_DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]                  REQ_VALID;
  logic [NUM_REQ-1:0]                  REQ_RW;
  logic [NUM_REQ*C_AXI_ADDR_WIDTH-1:0] REQ_ADDR;
  logic [NUM_REQ*C_AXI_DATA_WIDTH-1:0] REQ_WDATA;
  logic [NUM_REQ-1:0]                  REQ_READY;
  logic [NUM_REQ-1:0]                  REQ_DONE;
  logic [C_AXI_DATA_WIDTH-1:0]         RSP_RDATA;
  logic                                RSP_ERR;
  logic [C_AXI_ADDR_WIDTH-1:0]         AMCI_WADDR;
  logic [C_AXI_DATA_WIDTH-1:0]         AMCI_WDATA;
  logic                                AMCI_WRITE;
  logic                                AMCI_WIDLE;
  logic [C_AXI_ADDR_WIDTH-1:0]         AMCI_RADDR;
  logic                                AMCI_READ;
  logic                                AMCI_RIDLE;
  logic [C_AXI_DATA_WIDTH-1:0]         AMCI_RDATA;
  logic                                TIMEOUT_FLAG;

  modport master (
    input  REQ_VALID, REQ_RW, REQ_ADDR, REQ_WDATA,
    input  AMCI_WIDLE, AMCI_RIDLE, AMCI_RDATA,
    output REQ_READY, REQ_DONE, RSP_RDATA, RSP_ERR,
    output AMCI_WADDR, AMCI_WDATA, AMCI_WRITE, AMCI_RADDR, AMCI_READ,
    output TIMEOUT_FLAG
  );

  modport slave (
    output REQ_VALID, REQ_RW, REQ_ADDR, REQ_WDATA,
    output AMCI_WIDLE, AMCI_RIDLE, AMCI_RDATA,
    input  REQ_READY, REQ_DONE, RSP_RDATA, RSP_ERR,
    input  AMCI_WADDR, AMCI_WDATA, AMCI_WRITE, AMCI_RADDR, AMCI_READ,
    input  TIMEOUT_FLAG
  );
endinterface

// File: rtl/amci_rr_arbiter.sv
// Round-robin arbiter sharing one AMCI user port between NUM_REQ requesters.
// One transaction (read or write) outstanding at a time; completion and read
// data are returned to the granted requester.
// Optional watchdog: define AMCI_ARB_TIMEOUT_EN to enable the WAIT timeout,
// the STALL state and the sticky TIMEOUT_FLAG.
module amci_rr_arbiter #(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESET,
  amci_rr_arbiter_if.master bus
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned AW = C_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_AXI_DATA_WIDTH;

  // Elaboration-time guard on the supported parameter range
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("amci_rr_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

`ifdef AMCI_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_STALL} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
`endif

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_grant, w_grant_nxt;
  logic [GW-1:0]   r_last_grant, w_last_grant_nxt;
  logic            r_is_write, w_is_write_nxt;
  logic [NUM_REQ-1:0] r_req_ready, w_req_ready_nxt;
  logic [NUM_REQ-1:0] r_req_done, w_req_done_nxt;
  logic [DW-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic            r_rsp_err, w_rsp_err_nxt;
  logic [AW-1:0]   r_waddr, w_waddr_nxt;
  logic [DW-1:0]   r_wdata, w_wdata_nxt;
  logic            r_write, w_write_nxt;
  logic [AW-1:0]   r_raddr, w_raddr_nxt;
  logic            r_read, w_read_nxt;
`ifdef AMCI_ARB_TIMEOUT_EN
  logic [CW-1:0]   r_wcnt, w_wcnt_nxt;
  logic            r_tflag, w_tflag_nxt;
`endif

  logic [AW-1:0]   w_req_addr  [NUM_REQ];
  logic [DW-1:0]   w_req_wdata [NUM_REQ];
  logic            w_any;
  logic [GW-1:0]   w_sel;
  logic [GW-1:0]   w_idx;
  logic            w_chan_idle;

  // Unflatten per-requester address/data slices
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign w_req_addr[i]  = bus.REQ_ADDR[i*AW +: AW];
    assign w_req_wdata[i] = bus.REQ_WDATA[i*DW +: DW];
  end

  // Round-robin pick: first valid requester after the last grant, wrapping
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = GW'((32'(r_last_grant) + k) % NUM_REQ);
      if (!w_any && bus.REQ_VALID[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  assign w_chan_idle = r_is_write ? bus.AMCI_WIDLE : bus.AMCI_RIDLE;

  // Next-state and next-register values; pulses default low so they last one cycle
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_is_write_nxt   = r_is_write;
    w_req_ready_nxt  = '0;
    w_req_done_nxt   = '0;
    w_rsp_rdata_nxt  = r_rsp_rdata;
    w_rsp_err_nxt    = r_rsp_err;
    w_waddr_nxt      = r_waddr;
    w_wdata_nxt      = r_wdata;
    w_write_nxt      = 1'b0;
    w_raddr_nxt      = r_raddr;
    w_read_nxt       = 1'b0;
`ifdef AMCI_ARB_TIMEOUT_EN
    w_wcnt_nxt       = r_wcnt;
    w_tflag_nxt      = r_tflag;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any && bus.AMCI_WIDLE && bus.AMCI_RIDLE) begin
          w_grant_nxt     = w_sel;
          w_is_write_nxt  = bus.REQ_RW[w_sel];
          w_req_ready_nxt = NUM_REQ'(1) << w_sel;
          if (bus.REQ_RW[w_sel]) begin
            w_waddr_nxt = w_req_addr[w_sel];
            w_wdata_nxt = w_req_wdata[w_sel];
            w_write_nxt = 1'b1;
          end else begin
            w_raddr_nxt = w_req_addr[w_sel];
            w_read_nxt  = 1'b1;
          end
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef AMCI_ARB_TIMEOUT_EN
        w_wcnt_nxt  = '0;
`endif
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_chan_idle) begin
          if (!r_is_write) begin
            w_rsp_rdata_nxt = bus.AMCI_RDATA;
          end
          w_req_done_nxt   = NUM_REQ'(1) << r_grant;
          w_rsp_err_nxt    = 1'b0;
          w_last_grant_nxt = r_grant;
          w_state_nxt      = S_DONE;
        end
`ifdef AMCI_ARB_TIMEOUT_EN
        else if (r_wcnt == CW'(TIMEOUT_CYCLES - 1)) begin
          w_req_done_nxt   = NUM_REQ'(1) << r_grant;
          w_rsp_err_nxt    = 1'b1;
          w_tflag_nxt      = 1'b1;
          w_last_grant_nxt = r_grant;
          w_state_nxt      = S_STALL;
        end else begin
          w_wcnt_nxt = r_wcnt + CW'(1);
        end
`endif
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
`ifdef AMCI_ARB_TIMEOUT_EN
      S_STALL: begin
        if (bus.AMCI_WIDLE && bus.AMCI_RIDLE) begin
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant bookkeeping and registered outputs
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_is_write   <= 1'b0;
      r_req_ready  <= '0;
      r_req_done   <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_write      <= 1'b0;
      r_raddr      <= '0;
      r_read       <= 1'b0;
`ifdef AMCI_ARB_TIMEOUT_EN
      r_wcnt       <= '0;
      r_tflag      <= 1'b0;
`endif
    end else begin
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_is_write   <= w_is_write_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_req_done   <= w_req_done_nxt;
      r_rsp_rdata  <= w_rsp_rdata_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
      r_waddr      <= w_waddr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_write      <= w_write_nxt;
      r_raddr      <= w_raddr_nxt;
      r_read       <= w_read_nxt;
`ifdef AMCI_ARB_TIMEOUT_EN
      r_wcnt       <= w_wcnt_nxt;
      r_tflag      <= w_tflag_nxt;
`endif
    end
  end

  assign bus.REQ_READY  = r_req_ready;
  assign bus.REQ_DONE   = r_req_done;
  assign bus.RSP_RDATA  = r_rsp_rdata;
  assign bus.RSP_ERR    = r_rsp_err;
  assign bus.AMCI_WADDR = r_waddr;
  assign bus.AMCI_WDATA = r_wdata;
  assign bus.AMCI_WRITE = r_write;
  assign bus.AMCI_RADDR = r_raddr;
  assign bus.AMCI_READ  = r_read;
`ifdef AMCI_ARB_TIMEOUT_EN
  assign bus.TIMEOUT_FLAG = r_tflag;
`else
  assign bus.TIMEOUT_FLAG = 1'b0;
`endif

endmodule
